// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator, four waveform shapes and
// attenuation, driving an 8-bit offset-binary DAC sample stream.
module dds_wave_gen #(
  parameter int PHASE_W  = 32,
  parameter int FTW_MULT = 21990
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wave_sel,
  input  logic [19:0] wave_freq,
  input  logic [1:0]  wave_a,
  output logic [7:0]  dac_data,
  output logic        wrap_pulse
);

  localparam int PROD_W = 35;

  logic [PROD_W-1:0]  prod;
  logic [PHASE_W-1:0] ftw_next;

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] ftw_q, ftw_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         a_q, a_d;
  logic [7:0]         s_q, s_d;
  logic [7:0]         dac_q, dac_d;
  logic               wrap_q, wrap_d;

  logic [PHASE_W:0]   sum;
  logic               carry;

  logic [7:0]         p;
  logic [6:0]         q;
  logic [7:0]         mag;
  logic [6:0]         t;
  logic signed [7:0]  y;

  function automatic logic [6:0] sin_lut(input logic [6:0] idx);
    logic [6:0] v;
    v = 7'd127;
    case (idx)
      7'd0:  v = 7'd0;
      7'd1:  v = 7'd3;
      7'd2:  v = 7'd6;
      7'd3:  v = 7'd9;
      7'd4:  v = 7'd12;
      7'd5:  v = 7'd16;
      7'd6:  v = 7'd19;
      7'd7:  v = 7'd22;
      7'd8:  v = 7'd25;
      7'd9:  v = 7'd28;
      7'd10: v = 7'd31;
      7'd11: v = 7'd34;
      7'd12: v = 7'd37;
      7'd13: v = 7'd40;
      7'd14: v = 7'd43;
      7'd15: v = 7'd46;
      7'd16: v = 7'd49;
      7'd17: v = 7'd51;
      7'd18: v = 7'd54;
      7'd19: v = 7'd57;
      7'd20: v = 7'd60;
      7'd21: v = 7'd63;
      7'd22: v = 7'd65;
      7'd23: v = 7'd68;
      7'd24: v = 7'd71;
      7'd25: v = 7'd73;
      7'd26: v = 7'd76;
      7'd27: v = 7'd78;
      7'd28: v = 7'd81;
      7'd29: v = 7'd83;
      7'd30: v = 7'd85;
      7'd31: v = 7'd88;
      7'd32: v = 7'd90;
      7'd33: v = 7'd92;
      7'd34: v = 7'd94;
      7'd35: v = 7'd96;
      7'd36: v = 7'd98;
      7'd37: v = 7'd100;
      7'd38: v = 7'd102;
      7'd39: v = 7'd104;
      7'd40: v = 7'd106;
      7'd41: v = 7'd107;
      7'd42: v = 7'd109;
      7'd43: v = 7'd111;
      7'd44: v = 7'd112;
      7'd45: v = 7'd113;
      7'd46: v = 7'd115;
      7'd47: v = 7'd116;
      7'd48: v = 7'd117;
      7'd49: v = 7'd118;
      7'd50: v = 7'd120;
      7'd51: v = 7'd121;
      7'd52: v = 7'd122;
      7'd53: v = 7'd122;
      7'd54: v = 7'd123;
      7'd55: v = 7'd124;
      7'd56: v = 7'd125;
      7'd57: v = 7'd125;
      7'd58: v = 7'd126;
      7'd59: v = 7'd126;
      7'd60: v = 7'd126;
      default: v = 7'd127;
    endcase
    return v;
  endfunction

  assign prod     = PROD_W'(wave_freq) * PROD_W'(FTW_MULT);
  assign ftw_next = PHASE_W'(prod >> 8);

  // Parameters reload only on a wrap, or every edge while stopped
  always_comb begin
    sum     = {1'b0, phase_q} + {1'b0, ftw_q};
    carry   = sum[PHASE_W];
    phase_d = sum[PHASE_W-1:0];
    wrap_d  = carry;
    sel_d   = sel_q;
    a_d     = a_q;
    ftw_d   = ftw_q;
    if (carry || (ftw_q == '0)) begin
      sel_d = wave_sel;
      a_d   = wave_a;
      ftw_d = ftw_next;
    end
  end

  always_comb begin
    p   = phase_q[PHASE_W-1 -: 8];
    q   = p[6] ? (7'd64 - {1'b0, p[5:0]})
               : {1'b0, p[5:0]};
    mag = {1'b0, sin_lut(q)};
    t   = p[7] ? ~p[6:0] : p[6:0];
    s_d = '0;
    unique case (1'b1)
      sel_q == 2'd0: s_d = p[7] ? (8'd0 - mag) : mag;
      sel_q == 2'd1: s_d = p[7] ? 8'h81 : 8'h7f;
      sel_q == 2'd2: s_d = {t, 1'b0} - 8'd127;
      default:       s_d = {~p[7], p[6:0]};
    endcase
  end

  always_comb begin
    y     = $signed(s_q) >>> a_q;
    dac_d = y + 8'd128;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      ftw_q   <= '0;
      sel_q   <= '0;
      a_q     <= '0;
      s_q     <= '0;
      dac_q   <= 8'd128;
      wrap_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      ftw_q   <= ftw_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      s_q     <= s_d;
      dac_q   <= dac_d;
      wrap_q  <= wrap_d;
    end
  end

  assign dac_data   = dac_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Scoreboard bench for dds_wave_gen: stimulus queues expected samples by
// cycle, a negedge monitor pops and compares them.
module tb_dds_wave_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  wave_sel = 2'd0;
  logic [19:0] wave_freq = 20'd0;
  logic [1:0]  wave_a = 2'd0;
  logic [7:0]  dac_data;
  logic        wrap_pulse;

  always #10 clk = ~clk;

  dds_wave_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wave_sel   (wave_sel),
    .wave_freq  (wave_freq),
    .wave_a     (wave_a),
    .dac_data   (dac_data),
    .wrap_pulse (wrap_pulse)
  );

  typedef struct {
    int         cyc;
    logic [7:0] dac;
    bit         cd;
    bit         wv;
    bit         cw;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    wrap_cnt = 0;
  exp_t  e;
  string nm;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wrap_pulse === 1'b1) wrap_cnt = wrap_cnt + 1;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.cyc < cyc) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s: entry for cycle %0d missed at cycle %0d",
                 nm, e.cyc, cyc);
      end else begin
        if (e.cd) begin
          checks = checks + 1;
          if (dac_data !== e.dac) begin
            errors = errors + 1;
            $display("FAIL %s: dac_data=%0d expected %0d (cycle %0d)",
                     nm, dac_data, e.dac, cyc);
          end
        end
        if (e.cw) begin
          checks = checks + 1;
          if (wrap_pulse !== e.wv) begin
            errors = errors + 1;
            $display("FAIL %s: wrap_pulse=%b expected %b (cycle %0d)",
                     nm, wrap_pulse, e.wv, cyc);
          end
        end
      end
    end
  end

  task automatic push(input int c, input logic [7:0] v, input bit cd,
                      input bit w, input bit cw, input string n);
    exp_t x;
    x.cyc = c;
    x.dac = v;
    x.cd  = cd;
    x.wv  = w;
    x.cw  = cw;
    exp_q.push_back(x);
    name_q.push_back(n);
  endtask

  task automatic exp_dac(input int c, input logic [7:0] v, input string n);
    push(c, v, 1'b1, 1'b0, 1'b0, n);
  endtask

  task automatic exp_wrap(input int c, input bit w, input string n);
    push(c, 8'd0, 1'b0, w, 1'b1, n);
  endtask

  task automatic exp_rst(input int c, input string n);
    push(c, 8'd128, 1'b1, 1'b0, 1'b1, n);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_wrap(input int lim, input string n, output int w);
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (wrap_pulse === 1'b1) begin
        w = cyc;
        return;
      end
    end
    checks = checks + 1;
    errors = errors + 1;
    $display("FAIL %s: no wrap_pulse within %0d cycles, required one", n, lim);
    w = cyc;
  endtask

  task automatic check_range(input string n, input int act,
                             input int lo, input int hi);
    checks = checks + 1;
    if (act < lo || act > hi) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d required %0d..%0d", n, act, lo, hi);
    end
  endtask

  initial begin
    int w1, w2, w3, w4, w5, w6, w7, wa, wb, wc, r, c0, x;

    repeat (3) @(negedge clk);
    exp_rst(cyc + 1, "reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    wrap_cnt = 0;
    for (int i = 10; i <= 100; i += 30) exp_dac(c0 + i, 8'd128, "idle_dac");
    wait_until(c0 + 101);
    check_range("idle_no_wrap", wrap_cnt, 0, 0);

    wave_sel  = 2'd1;
    wave_freq = 20'd10000;
    c0 = cyc;
    exp_dac(c0 + 3, 8'd255, "sq_start");
    wait_wrap(6000, "sq_w1", w1);
    exp_wrap(w1 + 1, 1'b0, "wrap_one_cycle");
    exp_dac(w1 + 102, 8'd255, "sq_hi_early");
    exp_dac(w1 + 2402, 8'd255, "sq_hi_late");
    exp_dac(w1 + 2602, 8'd1, "sq_lo_early");
    exp_dac(w1 + 4902, 8'd1, "sq_lo_late");
    wait_wrap(5100, "sq_w2", w2);
    check_range("sq_period", w2 - w1, 5000, 5001);

    exp_dac(w2 + 102, 8'd255, "a0_hi");
    wait_until(w2 + 1000);
    wave_a = 2'd1;
    exp_dac(w2 + 1100, 8'd255, "a1_hold_hi");
    exp_dac(w2 + 2602, 8'd1, "a1_hold_lo");
    wait_wrap(5100, "a1_w3", w3);
    check_range("a1_period", w3 - w2, 5000, 5001);
    exp_dac(w3 + 102, 8'd191, "a1_hi");
    exp_dac(w3 + 2602, 8'd64, "a1_lo");
    wait_until(w3 + 3000);
    wave_a = 2'd3;
    exp_dac(w3 + 3100, 8'd64, "a3_hold");
    wait_wrap(5100, "a3_w4", w4);
    exp_dac(w4 + 102, 8'd143, "a3_hi");
    exp_dac(w4 + 2602, 8'd112, "a3_lo");
    wait_until(w4 + 3000);
    wave_sel  = 2'd3;
    wave_freq = 20'd100000;
    wave_a    = 2'd0;
    exp_dac(w4 + 3100, 8'd112, "saw_hold");

    wait_wrap(5100, "saw_w5", w5);
    wait_wrap(700, "saw_w6", w6);
    check_range("saw_first_period", w6 - w5, 500, 501);
    exp_dac(w6 + 2, 8'd0, "saw_0");
    exp_dac(w6 + 102, 8'd51, "saw_51");
    exp_dac(w6 + 202, 8'd102, "saw_102");
    exp_dac(w6 + 301, 8'd153, "saw_153");
    exp_dac(w6 + 501, 8'd255, "saw_255");
    wait_wrap(700, "saw_w7", w7);
    check_range("saw_period", w7 - w6, 500, 501);
    exp_dac(w7 + 2, 8'd0, "saw_step_back");

    wait_until(w7 + 10);
    rst_n    = 1'b0;
    wave_sel = 2'd0;
    wave_a   = 2'd0;
    exp_rst(cyc + 1, "rst_hold");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    exp_dac(r + 3, 8'd128, "sin_p0");
    exp_dac(r + 5, 8'd131, "sin_p1");
    exp_dac(r + 7, 8'd134, "sin_p2");
    exp_dac(r + 23, 8'd159, "sin_p10");
    exp_dac(r + 66, 8'd218, "sin_p32");
    exp_dac(r + 129, 8'd255, "sin_p64");
    exp_dac(r + 254, 8'd128, "sin_p128");
    exp_dac(r + 379, 8'd1, "sin_p192");
    wait_until(r + 380);
    wave_sel  = 2'd1;
    wave_freq = 20'd10000;
    wait_wrap(700, "sin_wrap", wa);
    check_range("sin_wrap_cycle", wa - r, 502, 502);

    exp_dac(wa + 102, 8'd255, "sq2_hi");
    wait_until(wa + 1000);
    wave_sel  = 2'd2;
    wave_freq = 20'd20000;
    exp_dac(wa + 1100, 8'd255, "chg_hold_hi");
    exp_dac(wa + 2602, 8'd1, "chg_hold_lo");
    wait_wrap(5100, "chg_wb", wb);
    check_range("chg_old_period", wb - wa, 4991, 4991);
    exp_dac(wb + 2, 8'd1, "tri_start");
    exp_dac(wb + 602, 8'd123, "tri_rise");
    exp_dac(wb + 1252, 8'd255, "tri_peak");
    wait_wrap(2600, "tri_wc", wc);
    check_range("tri_period", wc - wb, 2500, 2501);

    wait_until(wc + 1300);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    x = cyc;
    exp_rst(x, "async_rst");
    exp_rst(x + 1, "rst_low");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    exp_dac(r + 3, 8'd1, "restart_p0");
    exp_dac(r + 603, 8'd123, "restart_rise");
    exp_wrap(r + 2501, 1'b0, "restart_prewrap");
    exp_wrap(r + 2502, 1'b1, "restart_wrap");
    exp_wrap(r + 2503, 1'b0, "restart_postwrap");

    for (int k = 0; k < 5000 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
